// File: rtl/sseg_scan_if.sv
// Bus between a seven-segment scan controller and the logic that feeds it.
// The master supplies the value, its load strobe and the digit enables.
// The slave (the scan controller) returns the digit drive and status signals.
interface sseg_scan_if;
  logic [15:0] value;
  logic        load;
  logic [3:0]  digit_en;
  logic [3:0]  num;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        pending;
  logic        frame_start;

  modport master (
    output value, load, digit_en,
    input  num, an, digit_idx, pending, frame_start
  );

  modport slave (
    input  value, load, digit_en,
    output num, an, digit_idx, pending, frame_start
  );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// Four-digit seven-segment scan controller.
// Each digit is lit for TICK_DIV cycles, then all anodes are off for BLANK_CYC
// cycles to suppress ghosting. New values wait in a shadow register and are
// committed only at the frame boundary, so a digit is never torn.
module sseg_scan_ctrl #(
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 2000,
  parameter int LZB       = 1
) (
  input logic       clk,
  input logic       reset,
  sseg_scan_if.slave bus
);

  typedef enum logic {SHOW, BLANK} state_t;

  localparam logic [23:0] SHOW_LAST  = 24'(TICK_DIV - 1);
  localparam logic [23:0] BLANK_LAST = (BLANK_CYC > 0) ? 24'(BLANK_CYC - 1) : 24'd0;
  localparam bit          NO_BLANK   = (BLANK_CYC == 0);

  state_t      state_q, state_n;
  logic [1:0]  idx_q, idx_n;
  logic [23:0] cnt_q, cnt_n;
  logic [15:0] disp_q, disp_n;
  logic [15:0] shadow_q, shadow_n;
  logic        pending_q, pending_n;
  logic        fs_q;
  logic        boot_q;
  logic [3:0]  num_q, num_n;
  logic [3:0]  an_q, an_n;
  logic        wrap;

  // A digit is dark when disabled, or (with LZB) when it and every digit
  // above it hold zero. Digit 0 always shows so a zero value reads "0".
  function automatic logic digit_dark(input logic [15:0] d, input logic [1:0] k,
                                      input logic [3:0] en);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int j = 0; j < 4; j++)
      if (j >= int'(k) && d[4*j +: 4] != 4'h0) upper_zero = 1'b0;
    return !en[k] || ((LZB != 0) && (k != 2'd0) && upper_zero);
  endfunction

  // Next state, commit and output values, so every output is registered
  // together with the state it belongs to.
  always_comb begin
    state_n   = state_q;
    idx_n     = idx_q;
    cnt_n     = cnt_q + 24'd1;
    wrap      = 1'b0;
    case (state_q)
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_n = 24'd0;
          if (NO_BLANK) begin
            idx_n = idx_q + 2'd1;
            wrap  = (idx_q == 2'd3);
          end else begin
            state_n = BLANK;
          end
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_n   = 24'd0;
          state_n = SHOW;
          idx_n   = idx_q + 2'd1;
          wrap    = (idx_q == 2'd3);
        end
      end
      default: begin
        state_n = SHOW;
        cnt_n   = 24'd0;
      end
    endcase

    // A load landing on the commit edge goes straight to the display.
    shadow_n  = bus.load ? bus.value : shadow_q;
    disp_n    = disp_q;
    pending_n = pending_q;
    if (wrap) begin
      pending_n = 1'b0;
      if (bus.load)       disp_n = bus.value;
      else if (pending_q) disp_n = shadow_q;
    end else if (bus.load) begin
      pending_n = 1'b1;
    end

    num_n = num_q;
    an_n  = 4'b1111;
    if (state_n == SHOW) begin
      num_n = disp_n[{idx_n, 2'b00} +: 4];
      if (!digit_dark(disp_n, idx_n, bus.digit_en))
        an_n = ~(4'b0001 << idx_n);
    end
  end

  // State, counter, buffers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SHOW;
      idx_q     <= 2'd0;
      cnt_q     <= 24'd0;
      disp_q    <= 16'h0000;
      shadow_q  <= 16'h0000;
      pending_q <= 1'b0;
      fs_q      <= 1'b0;
      boot_q    <= 1'b1;
      num_q     <= 4'h0;
      an_q      <= bus.digit_en[0] ? 4'b1110 : 4'b1111;
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      cnt_q     <= cnt_n;
      disp_q    <= disp_n;
      shadow_q  <= shadow_n;
      pending_q <= pending_n;
      fs_q      <= wrap | boot_q;
      boot_q    <= 1'b0;
      num_q     <= num_n;
      an_q      <= an_n;
    end
  end

  assign bus.num         = num_q;
  assign bus.an          = an_q;
  assign bus.digit_idx   = idx_q;
  assign bus.pending     = pending_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: one instance with blanking (4/2) and one without
// (4/0). Stimulus threads push time-stamped expectations into a queue; a
// monitor samples the outputs on every falling edge and checks due entries.
module tb_sseg_scan_ctrl;

  localparam logic [4:0] M_AN = 5'b00001, M_NUM = 5'b00010, M_IDX = 5'b00100,
                         M_PEND = 5'b01000, M_FS = 5'b10000, M_ALL = 5'b11111;

  typedef struct {
    int         dut;
    int         stamp;
    logic [4:0] mask;
    logic [3:0] an;
    logic [3:0] num;
    logic [1:0] idx;
    logic       pend;
    logic       fs;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rsta = 1'b1;
  logic rstb = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sseg_scan_if ifa ();
  sseg_scan_if ifb ();

  sseg_scan_ctrl #(.TICK_DIV(4), .BLANK_CYC(2), .LZB(1)) dut_a (
    .clk(clk), .reset(rsta), .bus(ifa)
  );
  sseg_scan_ctrl #(.TICK_DIV(4), .BLANK_CYC(0), .LZB(1)) dut_b (
    .clk(clk), .reset(rstb), .bus(ifb)
  );

  task automatic expect_out(input int dut, input int stamp, input logic [4:0] mask,
                            input logic [3:0] an, input logic [3:0] num,
                            input logic [1:0] idx, input logic pend, input logic fs,
                            input string name);
    exp_t e;
    e.dut = dut; e.stamp = stamp; e.mask = mask; e.an = an; e.num = num;
    e.idx = idx; e.pend = pend; e.fs = fs; e.name = name;
    sbq.push_back(e);
  endtask

  // One frame: per digit d, TICK cycles with an_pat[d] and nums[d], then
  // BLANK cycles dark with num held; frame_start only in the very first cycle.
  task automatic push_frame(input int dut, input int base, input int tick, input int blank,
                            input logic [15:0] an_pat, input logic [15:0] nums,
                            input string name);
    int t;
    logic [3:0] a, n;
    t = base;
    for (int d = 0; d < 4; d++) begin
      a = an_pat[4*d +: 4];
      n = nums[4*d +: 4];
      for (int k = 0; k < tick; k++) begin
        expect_out(dut, t, M_AN | M_NUM | M_IDX | M_FS, a, n, 2'(d), 1'b0,
                   (d == 0 && k == 0), name);
        t++;
      end
      for (int k = 0; k < blank; k++) begin
        expect_out(dut, t, M_AN | M_NUM | M_IDX | M_FS, 4'hF, n, 2'(d), 1'b0, 1'b0, name);
        t++;
      end
    end
  endtask

  task automatic check_one(input exp_t e);
    logic [3:0] an, num;
    logic [1:0] idx;
    logic       pend, fs, ok;
    if (e.dut == 0) begin
      an = ifa.an; num = ifa.num; idx = ifa.digit_idx; pend = ifa.pending; fs = ifa.frame_start;
    end else begin
      an = ifb.an; num = ifb.num; idx = ifb.digit_idx; pend = ifb.pending; fs = ifb.frame_start;
    end
    ok = 1'b1;
    if (e.mask[0] && an   !== e.an)   ok = 1'b0;
    if (e.mask[1] && num  !== e.num)  ok = 1'b0;
    if (e.mask[2] && idx  !== e.idx)  ok = 1'b0;
    if (e.mask[3] && pend !== e.pend) ok = 1'b0;
    if (e.mask[4] && fs   !== e.fs)   ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got an=%b num=%h idx=%0d pend=%b fs=%b, want an=%b num=%h idx=%0d pend=%b fs=%b (mask %b)",
               e.name, e.dut, cyc, an, num, idx, pend, fs, e.an, e.num, e.idx, e.pend, e.fs, e.mask);
    end
  endtask

  // Monitor: check every expectation that falls due in this cycle.
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sbq.size()) begin
      if (sbq[i].stamp == cyc) begin
        check_one(sbq[i]);
        sbq.delete(i);
      end else if (sbq[i].stamp < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s dut%0d: expectation for cycle %0d never sampled", sbq[i].name,
                 sbq[i].dut, sbq[i].stamp);
        sbq.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic load_a(input int n, input logic [15:0] v);
    at(n);
    ifa.value = v; ifa.load = 1'b1;
    at(n + 1);
    ifa.load = 1'b0;
  endtask

  initial begin
    int rc, b, c, rcb;
    ifa.value = 16'h0; ifa.load = 1'b0; ifa.digit_en = 4'hF;
    ifb.value = 16'h0; ifb.load = 1'b0; ifb.digit_en = 4'hF;
    fork
      begin : thread_a
        at(2);
        expect_out(0, 3, M_ALL, 4'b1110, 4'h0, 2'd0, 1'b0, 1'b0, "reset_state");
        at(3);
        rc = cyc;
        rsta = 1'b0;
        b = rc + 24;
        c = b + 72;
        // First frame after reset shows 0 with digits 1-3 blanked.
        expect_out(0, rc + 1, M_AN | M_IDX | M_FS, 4'b1110, 4'h0, 2'd0, 1'b0, 1'b1, "boot_frame_start");
        expect_out(0, rc + 6, M_AN | M_IDX, 4'hF, 4'h0, 2'd1, 1'b0, 1'b0, "lzb_zero_d1");
        expect_out(0, rc + 10, M_PEND, 4'h0, 4'h0, 2'd0, 1'b1, 1'b0, "pending_after_load");
        expect_out(0, rc + 12, M_AN | M_NUM | M_IDX, 4'hF, 4'h0, 2'd2, 1'b0, 1'b0, "lzb_zero_d2");
        expect_out(0, b - 1, M_ALL, 4'hF, 4'h0, 2'd3, 1'b1, 1'b0, "no_early_commit");
        push_frame(0, b, 4, 2, 16'h7BDE, 16'h1234, "frame_1234");
        expect_out(0, b, M_PEND, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, "commit_clears_pending");
        load_a(rc + 1, 16'h1234);
        // ABCD loaded during digit 1 waits for the next frame.
        expect_out(0, b + 8, M_PEND, 4'h0, 4'h0, 2'd0, 1'b1, 1'b0, "pending_abcd");
        push_frame(0, b + 24, 4, 2, 16'h7BDE, 16'hABCD, "frame_abcd");
        expect_out(0, b + 24, M_PEND, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, "commit_abcd");
        load_a(b + 7, 16'hABCD);
        // Load coinciding with the commit edge.
        push_frame(0, b + 48, 4, 2, 16'h7BDE, 16'h5A5A, "frame_5a5a_direct");
        expect_out(0, b + 48, M_PEND, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, "direct_no_pending0");
        expect_out(0, b + 49, M_PEND, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, "direct_no_pending1");
        load_a(b + 47, 16'h5A5A);
        // Leading-zero blanking.
        push_frame(0, c, 4, 2, 16'hFFFE, 16'h0007, "lzb_0007");
        load_a(b + 50, 16'h0007);
        push_frame(0, c + 24, 4, 2, 16'hFBDE, 16'h0400, "lzb_0400");
        load_a(c + 2, 16'h0400);
        // Digit enables 0101 with FFFF.
        push_frame(0, c + 48, 4, 2, 16'hFBFE, 16'hFFFF, "digit_en_0101");
        load_a(c + 26, 16'hFFFF);
        at(c + 47);
        ifa.digit_en = 4'b0101;
        // Enable change in the middle of a dwell.
        expect_out(0, c + 72, M_AN | M_FS, 4'b1110, 4'h0, 2'd0, 1'b0, 1'b1, "dyn_en_before");
        expect_out(0, c + 73, M_AN, 4'b1110, 4'h0, 2'd0, 1'b0, 1'b0, "dyn_en_hold");
        expect_out(0, c + 74, M_AN, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0, "dyn_en_off");
        expect_out(0, c + 75, M_AN, 4'b1110, 4'h0, 2'd0, 1'b0, 1'b0, "dyn_en_on");
        at(c + 73);
        ifa.digit_en = 4'b0100;
        at(c + 74);
        ifa.digit_en = 4'hF;
        // Reset in the middle of digit 2 with a pending load.
        expect_out(0, c + 84, M_ALL, 4'b1011, 4'hF, 2'd2, 1'b1, 1'b0, "pending_before_reset");
        expect_out(0, c + 86, M_ALL, 4'b1110, 4'h0, 2'd0, 1'b0, 1'b0, "mid_frame_reset");
        expect_out(0, c + 87, M_AN | M_NUM | M_IDX | M_FS, 4'b1110, 4'h0, 2'd0, 1'b0, 1'b1, "post_reset_fs");
        expect_out(0, c + 92, M_AN | M_IDX, 4'hF, 4'h0, 2'd1, 1'b0, 1'b0, "post_reset_disp0");
        expect_out(0, c + 110, M_ALL, 4'b1110, 4'h0, 2'd0, 1'b0, 1'b1, "load_discarded");
        load_a(c + 76, 16'h1111);
        at(c + 85);
        rsta = 1'b1;
        at(c + 86);
        rsta = 1'b0;
        at(c + 112);
      end
      begin : thread_b
        at(3);
        rcb = cyc;
        rstb = 1'b0;
        expect_out(1, rcb + 1, M_AN | M_IDX | M_FS, 4'b1110, 4'h0, 2'd0, 1'b0, 1'b1, "b_boot_fs");
        push_frame(1, rcb + 16, 4, 0, 16'h7BDE, 16'h1234, "b_noblank_f1");
        push_frame(1, rcb + 32, 4, 0, 16'h7BDE, 16'h1234, "b_noblank_f2");
        at(rcb + 1);
        ifb.value = 16'h1234; ifb.load = 1'b1;
        at(rcb + 2);
        ifb.load = 1'b0;
        at(rcb + 50);
      end
    join
    for (int k = 0; k < 50 && sbq.size() != 0; k++) @(negedge clk);
    while (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s dut%0d: expectation for cycle %0d left unchecked", sbq[0].name,
               sbq[0].dut, sbq[0].stamp);
      sbq.delete(0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
- Scan controller for the 4-digit seven-segment display on the board top level.
- Time-multiplexes a 16-bit value across the four anodes, with a programmable dwell per digit and a dead-time blanking interval between digits to suppress ghosting.
- Double-buffers the displayed value so an update is applied only at a frame boundary, which prevents torn digits.
- Drives the 4-bit nibble input of sseg_driver and the active-low anode bus AN.

Parameters:
- TICK_DIV, 100000, clock cycles each digit is lit (SHOW dwell); legal range 1 to 2^24-1.
- BLANK_CYC, 2000, clock cycles all anodes are off between digits; 0 means no blanking phase.
- LZB, 1, 1 enables leading-zero blanking, 0 disables it.

Ports:
- clk  input  1  system clock (100 MHz).
- reset  input  1  synchronous, active-high reset.
- value  input  16  value to display; nibble k is shown on digit k (digit 0 is rightmost, AN[0]).
- load  input  1  one-cycle strobe; captures value into the shadow register.
- digit_en  input  4  per-digit enable; a 0 forces that digit dark.
- num  output  4  nibble for the currently scanned digit, feeds sseg_driver.
- an  output  4  anode select, active-low, at most one bit low at a time.
- digit_idx  output  2  index of the digit currently scanned.
- pending  output  1  shadow holds a loaded value not yet committed to display.
- frame_start  output  1  one-cycle pulse when digit 0 begins SHOW.

Behaviour:
- Clocking and reset
  - Single clock. Reset is synchronous and active-high; it takes effect on the clk edge and has priority over every other input.
  - Reset values: state=SHOW, digit_idx=0, dwell counter=0, disp=16'h0000, shadow=16'h0000, pending=0, frame_start=0, num=0.
  - an during reset follows the SHOW rules for disp=0, digit 0, so an=4'b1110 when digit_en[0]=1.
  - Reset asserted mid-frame returns to this state on the next edge. Any uncommitted load is discarded.
- State machine (SHOW, BLANK)
  - All outputs are registered; they change on the same edge as state and digit_idx.
  - SHOW: held for exactly TICK_DIV cycles, then go to BLANK, or go directly to the next SHOW if BLANK_CYC=0.
  - BLANK: held for exactly BLANK_CYC cycles, then go to SHOW with digit_idx+1 (wraps from 3 to 0).
  - Frame length = 4*(TICK_DIV+BLANK_CYC) cycles.
  - A single dwell counter counts 0 to limit-1 and clears on each state change.
- Outputs in SHOW
  - num = disp[4*digit_idx +: 4].
  - an = ~(4'b0001 << digit_idx), unless the digit is dark, in which case an = 4'b1111.
  - A digit is dark if digit_en[digit_idx]=0, or if it is blanked by LZB.
  - LZB blanking, when LZB=1: digit k (k=1..3) is dark when every nibble of disp from k up to 3 is zero. Digit 0 is never LZB-blanked.
- Outputs in BLANK: an=4'b1111; num holds its last value.
- Commit (frame boundary)
  - Occurs on the edge entering SHOW with digit_idx=0, i.e. leaving digit 3.
  - If pending=1, then disp<=shadow and pending<=0.
  - frame_start pulses high for the first cycle of SHOW at digit 0. It also pulses in the first cycle after reset.
- Load
  - load=1 sets shadow<=value and pending<=1.
  - Back-to-back loads: the last load before the commit edge wins.
  - If load and the commit edge coincide, the value on the value port is written directly into disp and pending stays 0. This load is not lost and not delayed.
- Dynamic inputs
  - digit_en and a change in LZB blanking take effect on the next edge, including mid-dwell. No glitch beyond the one-cycle register delay.

Test Plan (TICK_DIV=4, BLANK_CYC=2, LZB=1, 24-cycle frame):
- Reset then load value=16'h1234, digit_en=4'hF:
  - frame_start every 24 cycles.
  - an sequence per frame: 1110 ×4, 1111 ×2, 1101 ×4, 1111 ×2, 1011 ×4, 1111 ×2, 0111 ×4, 1111 ×2.
  - num = 4,3,2,1 during the matching SHOW windows.
  - 1234 appears only after the next frame_start.
- Load 16'hABCD while digit 1 is shown:
  - pending=1 and digits keep showing the old value until the digit-0 SHOW.
  - Then num=D at digit 0 and pending=0.
- Assert load exactly on the commit edge with value=16'h5A5A:
  - disp=5A5A in that same frame; pending stays 0.
- disp=16'h0007, LZB=1:
  - only AN[0] ever goes low; an=1111 throughout digit 1-3 windows.
  - disp=16'h0400 → digits 0,1,2 lit, digit 3 dark.
- digit_en=4'b0101, value=16'hFFFF: an never equals 1101 or 0111; the digit 1 and 3 windows read 1111.
- Assert reset for 1 cycle mid-digit-2 with pending=1:
  - next edge gives digit_idx=0, an=1110, num=0, pending=0, disp=0.
- Set BLANK_CYC=0: an never reads 1111 while all digits are enabled and nonzero; frame length is 16 cycles.
